// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side, forwarding and ALU-side signals for the ID/EX stage.
// master = the surrounding pipeline / bench, slave = id_ex_stage.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  // No valid/ready pair here: the stage advances every cycle, STALL holds all
  // stage registers and FLUSH (which wins over STALL) loads an all-zero bubble.
  logic              STALL;
  logic              FLUSH;
  logic [DATA_W-1:0] RS_DATA;
  logic [DATA_W-1:0] RT_DATA;
  logic [DATA_W-1:0] IMM;
  logic [REG_AW-1:0] RS;
  logic [REG_AW-1:0] RT;
  logic [REG_AW-1:0] RD;
  logic              REG_WRITE;
  logic              MEM_TO_REG;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic              BRANCH;
  logic              ALU_SRC;
  logic              REG_DST;
  logic [1:0]        ALU_OP;
  logic [5:0]        FUNCT;
  logic [REG_AW-1:0] IFID_RS;
  logic [REG_AW-1:0] IFID_RT;
  logic              EXMEM_REG_WRITE;
  logic [REG_AW-1:0] EXMEM_RD;
  logic [DATA_W-1:0] EXMEM_RESULT;
  logic              MEMWB_REG_WRITE;
  logic [REG_AW-1:0] MEMWB_RD;
  logic [DATA_W-1:0] MEMWB_RESULT;
  logic [DATA_W-1:0] ALU_IN1;
  logic [DATA_W-1:0] ALU_IN2;
  logic [3:0]        ALU_CONTROL;
  logic [DATA_W-1:0] STORE_DATA;
  logic [REG_AW-1:0] WRITE_REG;
  logic              EX_REG_WRITE;
  logic              EX_MEM_TO_REG;
  logic              EX_MEM_READ;
  logic              EX_MEM_WRITE;
  logic              EX_BRANCH;
  logic              LOAD_USE;

  modport master (
    output STALL, FLUSH, RS_DATA, RT_DATA, IMM, RS, RT, RD,
           REG_WRITE, MEM_TO_REG, MEM_READ, MEM_WRITE, BRANCH, ALU_SRC, REG_DST,
           ALU_OP, FUNCT, IFID_RS, IFID_RT,
           EXMEM_REG_WRITE, EXMEM_RD, EXMEM_RESULT,
           MEMWB_REG_WRITE, MEMWB_RD, MEMWB_RESULT,
    input  ALU_IN1, ALU_IN2, ALU_CONTROL, STORE_DATA, WRITE_REG,
           EX_REG_WRITE, EX_MEM_TO_REG, EX_MEM_READ, EX_MEM_WRITE, EX_BRANCH,
           LOAD_USE
  );

  modport slave (
    input  STALL, FLUSH, RS_DATA, RT_DATA, IMM, RS, RT, RD,
           REG_WRITE, MEM_TO_REG, MEM_READ, MEM_WRITE, BRANCH, ALU_SRC, REG_DST,
           ALU_OP, FUNCT, IFID_RS, IFID_RT,
           EXMEM_REG_WRITE, EXMEM_RD, EXMEM_RESULT,
           MEMWB_REG_WRITE, MEMWB_RD, MEMWB_RESULT,
    output ALU_IN1, ALU_IN2, ALU_CONTROL, STORE_DATA, WRITE_REG,
           EX_REG_WRITE, EX_MEM_TO_REG, EX_MEM_READ, EX_MEM_WRITE, EX_BRANCH,
           LOAD_USE
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding, ALU control
// decode and load-use detection. Optional macro ID_EX_WB_BYPASS_EN adds WB bypass at capture.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic          CLK,
  input  logic          RESET,
  id_ex_stage_if.slave  bus
);

  logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  logic              reg_write_q, mem_to_reg_q, mem_read_q, mem_write_q;
  logic              branch_q, alu_src_q, reg_dst_q;
  logic [1:0]        alu_op_q;
  logic [5:0]        funct_q;

  logic [DATA_W-1:0] rs_cap, rt_cap;
  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic [3:0]        alu_control;

`ifdef ID_EX_WB_BYPASS_EN
  // Register file reads before it writes, so a same-cycle WB must be caught here.
  always_comb begin
    rs_cap = bus.RS_DATA;
    rt_cap = bus.RT_DATA;
    if (bus.MEMWB_REG_WRITE && (bus.MEMWB_RD != '0) && (bus.MEMWB_RD == bus.RS))
      rs_cap = bus.MEMWB_RESULT;
    if (bus.MEMWB_REG_WRITE && (bus.MEMWB_RD != '0) && (bus.MEMWB_RD == bus.RT))
      rt_cap = bus.MEMWB_RESULT;
  end
`else
  assign rs_cap = bus.RS_DATA;
  assign rt_cap = bus.RT_DATA;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET || (bus.FLUSH)) begin
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      alu_op_q     <= '0;
      funct_q      <= '0;
    end else if (!bus.STALL) begin
      rs_data_q    <= rs_cap;
      rt_data_q    <= rt_cap;
      imm_q        <= bus.IMM;
      rs_q         <= bus.RS;
      rt_q         <= bus.RT;
      rd_q         <= bus.RD;
      reg_write_q  <= bus.REG_WRITE;
      mem_to_reg_q <= bus.MEM_TO_REG;
      mem_read_q   <= bus.MEM_READ;
      mem_write_q  <= bus.MEM_WRITE;
      branch_q     <= bus.BRANCH;
      alu_src_q    <= bus.ALU_SRC;
      reg_dst_q    <= bus.REG_DST;
      alu_op_q     <= bus.ALU_OP;
      funct_q      <= bus.FUNCT;
    end
  end

  // EX/MEM is the younger result, so it takes precedence over MEM/WB.
  always_comb begin
    fwd_a = rs_data_q;
    if (bus.EXMEM_REG_WRITE && (bus.EXMEM_RD != '0) && (bus.EXMEM_RD == rs_q))
      fwd_a = bus.EXMEM_RESULT;
    else if (bus.MEMWB_REG_WRITE && (bus.MEMWB_RD != '0) && (bus.MEMWB_RD == rs_q))
      fwd_a = bus.MEMWB_RESULT;
  end

  always_comb begin
    fwd_b = rt_data_q;
    if (bus.EXMEM_REG_WRITE && (bus.EXMEM_RD != '0) && (bus.EXMEM_RD == rt_q))
      fwd_b = bus.EXMEM_RESULT;
    else if (bus.MEMWB_REG_WRITE && (bus.MEMWB_RD != '0) && (bus.MEMWB_RD == rt_q))
      fwd_b = bus.MEMWB_RESULT;
  end

  always_comb begin
    alu_control = 4'b0010;
    if (alu_op_q == 2'b01) begin
      alu_control = 4'b0110;
    end else if (alu_op_q == 2'b10) begin
      case (funct_q)
        6'b100010: alu_control = 4'b0110;
        6'b100100: alu_control = 4'b0000;
        6'b100101: alu_control = 4'b0011;
        6'b101010: alu_control = 4'b0100;
        default:   alu_control = 4'b0010;
      endcase
    end
  end

  assign bus.ALU_IN1       = fwd_a;
  assign bus.ALU_IN2       = alu_src_q ? imm_q : fwd_b;
  assign bus.STORE_DATA    = fwd_b;
  assign bus.ALU_CONTROL   = alu_control;
  assign bus.WRITE_REG     = reg_dst_q ? rd_q : rt_q;
  assign bus.EX_REG_WRITE  = reg_write_q;
  assign bus.EX_MEM_TO_REG = mem_to_reg_q;
  assign bus.EX_MEM_READ   = mem_read_q;
  assign bus.EX_MEM_WRITE  = mem_write_q;
  assign bus.EX_BRANCH     = branch_q;
  assign bus.LOAD_USE      = mem_read_q && (rt_q != '0) &&
                             ((rt_q == bus.IFID_RS) || (rt_q == bus.IFID_RT));

endmodule
